keypad_scan_ctrl: RTL and testbench
===================================

# keypad_scan_ctrl

Scan sequencer and debouncer for the vending machine's 4x4 matrix keypad. Drives the active-low column lines one at a time, samples the synchronised row lines and debounces both press and release. Emits exactly one key event per physical press to the vending FSM over a valid/ready handshake. Sits between the keypad pins and the vending controller; it replaces free-running column rotation and level-style key decoding.

## Interface
- `SETTLE_CYCLES`, default 16: cycles each column is driven before rows are sampled; must be ≥3.
- `DEBOUNCE_CYCLES`, default 1000: consecutive stable cycles required to accept a press or a release; must be ≥2.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low.
- `row` in 4: keypad rows, active-low, pulled up, asynchronous to `clk`.
- `col` out 4: column drive, active-low, exactly one bit low at all times.
- `key_valid` out 1: key event available.
- `key_code` out 4: event code = col_index*4 + row_index, where an index is the position of the low bit.
- `key_ready` in 1: consumer accepts the event when `key_valid` and `key_ready` are both high.
- `key_held` out 1: high while an accepted press is held (states PRESSED and RELEASE).
- `overrun` out 1: one-cycle pulse when an event is dropped.

## Operation
- `row` passes through a 2-flop synchroniser reset to 4'hF. All decisions use the synchronised value, `rs`.
- SCAN:
  - Drive column k and count settle cycles.
  - On settle count SETTLE_CYCLES-1, sample `rs`.
  - If `rs` has exactly one low bit: capture the pattern and go to DEBOUNCE, with `col` held.
  - If `rs` is 4'hF or has two or more low bits (ghosting): k←(k+1) mod 4, wrapping 3→0, and restart the settle count.
- DEBOUNCE:
  - Each cycle, compare `rs` with the captured pattern.
  - On a mismatch: go back to SCAN on the same column with the settle count cleared.
  - After DEBOUNCE_CYCLES consecutive matches: go to PRESSED and post the event.
- PRESSED:
  - `col` is held.
  - The first cycle with `rs` = 4'hF clears the counter and enters RELEASE.
- RELEASE:
  - Any low bit in `rs`: return to PRESSED. No new event is posted.
  - After DEBOUNCE_CYCLES consecutive cycles of 4'hF: go to SCAN on column (k+1) mod 4.
- Event register (single entry):
  - Posting loads `key_code` and sets `key_valid`.
  - `key_valid` clears only on acceptance.
  - `key_code` is stable while `key_valid` is high.
- Post while `key_valid`=1 and `key_ready`=0: the new event is dropped, `overrun` pulses, and `key_code` is unchanged.
- Post in the same cycle as an acceptance: the new code loads and `key_valid` stays 1. No overrun.
- `key_ready` is ignored while `key_valid`=0.
- Reset values: state SCAN, k=0, `col`=4'b1110, `key_valid`=0, `key_code`=0, `key_held`=0, `overrun`=0, all counters 0.
- Reset asserted mid-operation forces these values immediately (asynchronously). A pending event is lost.

## Timing
- Idle column period: SETTLE_CYCLES cycles per column, 4×SETTLE_CYCLES per full sweep.
- The synchroniser adds 2 cycles. SETTLE_CYCLES≥3 guarantees the sample reflects the current column.
- Press latency: the sample is taken in cycle t, DEBOUNCE runs for cycles t+1..t+DEBOUNCE_CYCLES, and `key_valid` is first high in cycle t+DEBOUNCE_CYCLES+1.
- `key_held` rises in the same cycle as the post.
- `key_held` falls in the cycle SCAN resumes.
- `overrun` is registered and high for exactly one cycle per dropped event.
- Counter widths are $clog2 of the respective parameter.
- There is no combinational path from `row` or `key_ready` to any output.

## Structure
- Shared package `keypad_pkg` holds:
  - the state enum (SCAN, DEBOUNCE, PRESSED, RELEASE);
  - `KEY_CODE_W`=4 and `NUM_COLS`=4;
  - the code-encoding function (col one-hot-low, row one-hot-low) → code;
  - a one-low-bit check function.
- Sub-module `keypad_row_sync`: a parameterised 2-flop synchroniser with a reset value input. The rest of the block is a single module.

## Test plan
All scenarios use SETTLE_CYCLES=4 and DEBOUNCE_CYCLES=8.
1. Reset, `row`=4'hF → `col` steps 1110→1101→1011→0111→1110, each for 4 cycles; `key_valid`=0 throughout.
2. Row 1101 pressed only while `col`=1011, held for 200 cycles, `key_ready`=1 → exactly one event with `key_code`=0x9; `key_valid` is high 1 cycle; `col` stays 1011 and `key_held`=1 until 8 cycles after release.
3. Press bounce: 1101 for 5 cycles, then 1111, repeated → no event and scanning continues. Release bounce: 1111 for 5 cycles inside RELEASE, then 1101 → no second event.
4. `key_ready`=0; press col0/row0 (code 0x0), release, then press col3/row3 → `key_code` stays 0x0, `overrun` pulses once. Raising `key_ready` for 1 cycle → `key_valid` falls.
5. Row 1100 on any column → treated as no press, no event, sweep continues.
6. `reset` low during PRESSED with `key_valid`=1 → all outputs take reset values asynchronously. After release of reset, the sweep restarts at 1110.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scan controller.
// Key codes are col_index*4 + row_index, where each index is the position of the low bit.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } key_state_t;

    localparam int KEY_CODE_W = 4;
    localparam int NUM_COLS   = 4;

    function automatic logic one_low(input logic [3:0] v);
        int zeros;
        zeros = 0;
        for (int i = 0; i < 4; i++) begin
            if (!v[i]) zeros++;
        end
        return (zeros == 1);
    endfunction

    function automatic logic [KEY_CODE_W-1:0] encode_key(input logic [NUM_COLS-1:0] col_n,
                                                         input logic [3:0]          row_n);
        logic [1:0] col_i;
        logic [1:0] row_i;
        col_i = '0;
        row_i = '0;
        for (int i = 0; i < 4; i++) begin
            if (!col_n[i]) col_i = i[1:0];
            if (!row_n[i]) row_i = i[1:0];
        end
        return {col_i, row_i};
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchroniser for the asynchronous keypad row lines.
// The reset value is an input so idle (pulled-up) rows read as released out of reset.
module keypad_row_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] reset_value,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= reset_value;
            q    <= reset_value;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad column scanner with press/release debounce and a single-entry event register.
// One key event is posted per debounced press; it is dropped with an overrun pulse if the register is still full.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 16,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            row,
    output logic [NUM_COLS-1:0]   col,
    output logic                  key_valid,
    output logic [KEY_CODE_W-1:0] key_code,
    input  logic                  key_ready,
    output logic                  key_held,
    output logic                  overrun
);

    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

    key_state_t            state, state_nxt;
    logic [1:0]            col_idx, col_idx_nxt;
    logic [SW-1:0]         settle_cnt, settle_nxt;
    logic [DW-1:0]         deb_cnt, deb_nxt;
    logic [3:0]            pattern, pattern_nxt;
    logic [3:0]            rs;
    logic                  post;
    logic [KEY_CODE_W-1:0] new_code;

    keypad_row_sync #(.WIDTH(4)) u_row_sync (
        .clk         (clk),
        .reset       (reset),
        .reset_value (4'hF),
        .d           (row),
        .q           (rs)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= SCAN;
            col_idx    <= '0;
            settle_cnt <= '0;
            deb_cnt    <= '0;
            pattern    <= 4'hF;
        end else begin
            state      <= state_nxt;
            col_idx    <= col_idx_nxt;
            settle_cnt <= settle_nxt;
            deb_cnt    <= deb_nxt;
            pattern    <= pattern_nxt;
        end
    end

    // A single-low-bit sample starts a debounce; blank or ghosted samples advance the column.
    always_comb begin
        state_nxt   = state;
        col_idx_nxt = col_idx;
        settle_nxt  = settle_cnt;
        deb_nxt     = deb_cnt;
        pattern_nxt = pattern;
        post        = 1'b0;
        case (state)
            SCAN: begin
                if (settle_cnt == SETTLE_LAST) begin
                    settle_nxt = '0;
                    if (one_low(rs)) begin
                        state_nxt   = DEBOUNCE;
                        pattern_nxt = rs;
                        deb_nxt     = '0;
                    end else begin
                        col_idx_nxt = col_idx + 2'd1;
                    end
                end else begin
                    settle_nxt = settle_cnt + SW'(1);
                end
            end
            DEBOUNCE: begin
                if (rs != pattern) begin
                    state_nxt  = SCAN;
                    settle_nxt = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt = PRESSED;
                    post      = 1'b1;
                end else begin
                    deb_nxt = deb_cnt + DW'(1);
                end
            end
            PRESSED: begin
                if (rs == 4'hF) begin
                    state_nxt = RELEASE;
                    deb_nxt   = '0;
                end
            end
            RELEASE: begin
                if (rs != 4'hF) begin
                    state_nxt = PRESSED;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt   = SCAN;
                    settle_nxt  = '0;
                    col_idx_nxt = col_idx + 2'd1;
                end else begin
                    deb_nxt = deb_cnt + DW'(1);
                end
            end
            default: state_nxt = SCAN;
        endcase
    end

    always_comb begin
        col      = ~(4'b0001 << col_idx);
        key_held = (state == PRESSED) || (state == RELEASE);
        new_code = encode_key(col, pattern);
    end

    // A post coinciding with acceptance reloads the register instead of overrunning.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_valid <= 1'b0;
            key_code  <= '0;
            overrun   <= 1'b0;
        end else begin
            overrun <= post && key_valid && !key_ready;
            if (post && (!key_valid || key_ready)) begin
                key_valid <= 1'b1;
                key_code  <= new_code;
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed and randomized bench for keypad_scan_ctrl with SETTLE_CYCLES=4, DEBOUNCE_CYCLES=8.
// A keypad matrix model drives the rows from the column lines; events are compared against pressed keys.
module tb_keypad_scan_ctrl;

    localparam int S = 4;
    localparam int D = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] row;
    logic [3:0] col;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready = 1'b0;
    logic       key_held;
    logic       overrun;

    logic       use_force = 1'b1;
    logic [3:0] force_row = 4'hF;
    logic       press_en = 1'b0;
    logic [1:0] press_col = 2'd0;
    logic [1:0] press_row = 2'd0;

    int check_cnt = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    int         ev_count = 0;
    int         valid_cycles = 0;
    int         overrun_cycles = 0;
    int         col_changes = 0;
    int         col_bad = 0;
    int         col_hits [4] = '{0, 0, 0, 0};
    logic       prev_valid = 1'b0;
    logic [3:0] prev_col = 4'hE;
    logic [3:0] got_codes [$];
    logic [3:0] exp_codes [$];

    keypad_scan_ctrl #(
        .SETTLE_CYCLES   (S),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .key_held  (key_held),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Physical keypad: the pressed key pulls its row low only while its column is driven.
    always_comb begin
        if (use_force)
            row = force_row;
        else if (press_en && !col[press_col])
            row = ~(4'b0001 << press_row);
        else
            row = 4'hF;
    end

    always @(negedge clk) begin
        if (key_valid && !prev_valid) begin
            ev_count <= ev_count + 1;
            got_codes.push_back(key_code);
        end
        if (key_valid) valid_cycles <= valid_cycles + 1;
        if (overrun) overrun_cycles <= overrun_cycles + 1;
        if (col != prev_col) col_changes <= col_changes + 1;
        case (col)
            4'b1110: col_hits[0] <= col_hits[0] + 1;
            4'b1101: col_hits[1] <= col_hits[1] + 1;
            4'b1011: col_hits[2] <= col_hits[2] + 1;
            4'b0111: col_hits[3] <= col_hits[3] + 1;
            default: col_bad <= col_bad + 1;
        endcase
        prev_valid <= key_valid;
        prev_col   <= col;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [1:0] pc, input logic [1:0] pr,
                                 input logic rdy, input int cycles);
        use_force = 1'b0;
        press_en  = en;
        press_col = pc;
        press_row = pr;
        key_ready = rdy;
        repeat (cycles) tick();
    endtask

    task automatic applyRows(input logic [3:0] v, input int cycles);
        use_force = 1'b1;
        force_row = v;
        repeat (cycles) tick();
    endtask

    task automatic doReset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        int ev_base;
        int vc_base;
        int ov_base;
        int cc_base;
        int got_base;
        int hits_base [4];
        int hold;
        logic [3:0] exp_col;
        logic [1:0] rc;
        logic [1:0] rr;

        $display("[TB] start");
        tick();
        tick();
        checkOutput("reset_col", col, 4'b1110);
        checkOutput("reset_valid", key_valid, 0);
        checkOutput("reset_code", key_code, 0);
        checkOutput("reset_held", key_held, 0);
        checkOutput("reset_overrun", overrun, 0);

        // Idle sweep: each column for S cycles, wrapping back to column 0.
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            exp_col = ~(4'b0001 << ((i / S) % 4));
            checkOutput("sweep_col", col, exp_col);
            checkOutput("sweep_valid", key_valid, 0);
            tick();
        end

        // Press col2/row1 from reset: sampled in cycle 11, valid first high in cycle 11+D+1.
        reset = 1'b0;
        use_force = 1'b0;
        press_en  = 1'b1;
        press_col = 2'd2;
        press_row = 2'd1;
        key_ready = 1'b1;
        tick();
        tick();
        ev_base = ev_count;
        vc_base = valid_cycles;
        reset = 1'b1;
        repeat (19) tick();
        checkOutput("latency_valid_before", key_valid, 0);
        checkOutput("latency_held_before", key_held, 0);
        tick();
        checkOutput("latency_valid_at", key_valid, 1);
        checkOutput("press_code", key_code, 4'h9);
        checkOutput("held_rise", key_held, 1);
        tick();
        checkOutput("valid_accepted", key_valid, 0);
        repeat (179) tick();
        checkOutput("held_col", col, 4'b1011);
        checkOutput("held_flag", key_held, 1);
        checkOutput("one_event", ev_count - ev_base, 1);
        checkOutput("valid_one_cycle", valid_cycles - vc_base, 1);
        press_en = 1'b0;
        repeat (10) tick();
        checkOutput("release_held_late", key_held, 1);
        checkOutput("release_col_late", col, 4'b1011);
        tick();
        checkOutput("release_held_fall", key_held, 0);
        checkOutput("release_next_col", col, 4'b0111);

        // Press bounce never reaches D stable cycles, so the sweep must keep moving.
        ev_base = ev_count;
        cc_base = col_changes;
        repeat (8) begin
            applyRows(4'b1101, 5);
            applyRows(4'hF, 5);
        end
        checkOutput("bounce_no_event", ev_count - ev_base, 0);
        checkOutput("bounce_not_held", key_held, 0);
        checkOutput("bounce_scanning", (col_changes > cc_base), 1);

        // Release bounce: a short release inside RELEASE must not produce a second event.
        applyStimulus(1'b1, 2'd1, 2'd2, 1'b1, 60);
        checkOutput("rb_event", ev_count - ev_base, 1);
        checkOutput("rb_code", key_code, 4'h6);
        checkOutput("rb_held", key_held, 1);
        applyStimulus(1'b0, 2'd1, 2'd2, 1'b1, 5);
        applyStimulus(1'b1, 2'd1, 2'd2, 1'b1, 20);
        checkOutput("rb_still_held", key_held, 1);
        checkOutput("rb_no_second", ev_count - ev_base, 1);
        applyStimulus(1'b0, 2'd1, 2'd2, 1'b1, 30);
        checkOutput("rb_released", key_held, 0);
        checkOutput("rb_total", ev_count - ev_base, 1);

        // Backpressure: second press is dropped with a single overrun pulse.
        ev_base = ev_count;
        ov_base = overrun_cycles;
        applyStimulus(1'b1, 2'd0, 2'd0, 1'b0, 60);
        checkOutput("bp_valid", key_valid, 1);
        checkOutput("bp_code", key_code, 4'h0);
        checkOutput("bp_event", ev_count - ev_base, 1);
        applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 30);
        applyStimulus(1'b1, 2'd3, 2'd3, 1'b0, 60);
        checkOutput("bp_code_kept", key_code, 4'h0);
        checkOutput("bp_valid_kept", key_valid, 1);
        checkOutput("bp_overrun", overrun_cycles - ov_base, 1);
        applyStimulus(1'b0, 2'd3, 2'd3, 1'b0, 30);
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        checkOutput("bp_accept", key_valid, 0);
        checkOutput("bp_overrun_once", overrun_cycles - ov_base, 1);

        // Two low rows are ghosting: no event, all columns keep being visited.
        ev_base = ev_count;
        for (int c = 0; c < 4; c++) hits_base[c] = col_hits[c];
        applyRows(4'b1100, 60);
        checkOutput("ghost_no_event", ev_count - ev_base, 0);
        checkOutput("ghost_not_held", key_held, 0);
        for (int c = 0; c < 4; c++)
            checkOutput("ghost_col_visited", (col_hits[c] > hits_base[c]), 1);

        // Asynchronous reset while a press is held with an event pending.
        applyStimulus(1'b1, 2'd2, 2'd3, 1'b0, 60);
        checkOutput("ar_valid_before", key_valid, 1);
        checkOutput("ar_code_before", key_code, 4'hB);
        checkOutput("ar_held_before", key_held, 1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        press_en = 1'b0;
        #1;
        checkOutput("ar_col", col, 4'b1110);
        checkOutput("ar_valid", key_valid, 0);
        checkOutput("ar_code", key_code, 0);
        checkOutput("ar_held", key_held, 0);
        checkOutput("ar_overrun", overrun, 0);
        tick();
        tick();
        reset = 1'b1;
        repeat (3) tick();
        checkOutput("ar_restart_col0", col, 4'b1110);
        tick();
        checkOutput("ar_restart_col1", col, 4'b1101);

        // Random keys with random backpressure while held; every press yields its own code.
        ov_base  = overrun_cycles;
        got_base = got_codes.size();
        exp_codes.delete();
        for (int n = 0; n < 8; n++) begin
            rc = 2'($urandom_range(0, 3));
            rr = 2'($urandom_range(0, 3));
            exp_codes.push_back({rc, rr});
            use_force = 1'b0;
            press_col = rc;
            press_row = rr;
            press_en  = 1'b1;
            hold = int'($urandom_range(40, 70));
            repeat (hold) begin
                key_ready = 1'($urandom_range(0, 1));
                tick();
            end
            press_en  = 1'b0;
            key_ready = 1'b1;
            hold = int'($urandom_range(25, 40));
            repeat (hold) tick();
        end
        checkOutput("rand_event_count", got_codes.size() - got_base, exp_codes.size());
        for (int j = 0; j < exp_codes.size(); j++) begin
            if (got_base + j < got_codes.size())
                checkOutput("rand_code", got_codes[got_base + j], exp_codes[j]);
        end
        checkOutput("rand_no_overrun", overrun_cycles - ov_base, 0);
        checkOutput("col_one_low_always", col_bad, 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
